universal_shift_register: RTL and testbench
===========================================

Name: universal_shift_register

Overview:
- Parametrised N-stage × W-bit universal shift register, successor to the serial-in serial-out shifter.
- Supports bidirectional shift, rotate, parallel load and synchronous clear.
- Includes a burst sequencer that performs CNT consecutive shift/rotate steps with a BUSY/DONE handshake.
- Used as a datapath staging and serialisation element in the SoC fabric.

Parameters:
N, 4, number of stages (N ≥ 2)
W, 1, bits per stage (word width)
CW, 4, width of burst count CNT
TAPS, {N{1'b1}}, feedback tap mask, one bit per stage (used only with USR_LFSR_EN)

Ports:
CLK  input  1  rising-edge clock
CLR  input  1  asynchronous active-low clear
EN  input  1  step enable; gates single ops and burst steps
MODE  input  3  op select: 000 hold, 001 shift up, 010 shift down, 011 rotate up, 100 rotate down, 101 parallel load, 110 sync clear, 111 hold/feedback
SIN_LO  input  W  word entering stage 0 on shift up
SIN_HI  input  W  word entering stage N-1 on shift down
D  input  N*W  parallel load data; stage i = D[i*W +: W]
START  input  1  burst request
CNT  input  CW  burst step count
Q  output  N*W  register contents; stage i = Q[i*W +: W]
SOUT_LO  output  W  stage 0 (combinational from Q)
SOUT_HI  output  W  stage N-1 (combinational from Q)
BUSY  output  1  burst in progress
DONE  output  1  one-cycle pulse at burst completion

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. CLR=0 forces Q=0, BUSY=0, DONE=0 and FSM=IDLE immediately, including mid-burst. Release is synchronous to CLK.
- Ops, each one step:
  - shift up: stage i ← i-1, stage 0 ← SIN_LO.
  - shift down: stage i ← i+1, stage N-1 ← SIN_HI.
  - rotate up: stage 0 ← stage N-1.
  - rotate down: stage N-1 ← stage 0.
  - load: Q ← D.
  - sync clear: Q ← 0.
- FSM states: IDLE, RUN. Registers: remaining counter (CW bits) and latched mode (3 bits).
- IDLE, START=1, MODE ∈ {001..100} (plus 111 when USR_LFSR_EN is defined):
  - Latch MODE; remaining ← CNT. EN is ignored for acceptance; no Q change on this edge.
  - CNT≠0: go to RUN, BUSY←1.
  - CNT=0: stay IDLE, DONE←1 for one cycle, Q unchanged.
- IDLE, START=1 with any other MODE: START is ignored; the MODE op executes as a single step if EN=1.
- IDLE, START=0: if EN=1, the MODE op executes on this edge; if EN=0, hold.
- RUN:
  - MODE and START are ignored.
  - Each edge with EN=1: one step of the latched mode, remaining decrements.
  - EN=0: pause, no decrement.
  - Edge where remaining goes 1→0: step executes, BUSY←0, DONE←1, return to IDLE.
- DONE is high for exactly one cycle, then clears. A START sampled in the same cycle as DONE=1 is accepted normally (back-to-back bursts).
- Burst latency: CNT + (number of EN=0 cycles in RUN) edges after the START edge.
- Reset values: Q=0, SOUT_LO=0, SOUT_HI=0, BUSY=0, DONE=0.

Optional Feature:
- USR_LFSR_EN defined:
  - MODE 111 = feedback shift up: stage i ← i-1, stage 0 ← XOR of all stages i with TAPS[i]=1 (word-wise XOR).
  - MODE 111 is valid as a single op and as a burst mode.
- USR_LFSR_EN undefined: MODE 111 = hold, START with MODE 111 is ignored, TAPS is unused.

Test Plan:
- Reset mid-burst: load 16'h1234 (N=4, W=4), start rotate-down burst CNT=5, pull CLR=0 after 2 steps -> Q=0, BUSY=0, DONE=0 asynchronously; no DONE after release.
- Parallel load, then hold: MODE=101, D=16'h1234, EN=1 -> Q=16'h1234 after one edge; EN=0 for 3 edges -> Q stays 16'h1234.
- Single shift up: Q=16'h1234, SIN_LO=4'hA, MODE=001, EN=1 -> Q=16'h234A; SOUT_HI 4'h1 before the edge, 4'h2 after.
- Rotate-down burst: Q=16'h1234, START, MODE=100, CNT=3 -> BUSY high 3 cycles, Q=16'h2341, DONE one cycle with BUSY=0.
- Paused burst: Q=16'h1234, START, MODE=010, SIN_HI=4'hF, CNT=2, EN=0 for one RUN cycle -> BUSY high 3 cycles, Q=16'hFF12, single DONE pulse.
- Zero-count burst: START, CNT=0 -> DONE high the next cycle, BUSY never asserted, Q unchanged. With USR_LFSR_EN, TAPS=4'b1001, Q=16'h1234, MODE=111 -> Q=16'h2345 (stage 0 ← 4'h1 ^ 4'h4).

Source files
------------

// File: rtl/universal_shift_register.sv
// N-stage x W-bit universal shift register with a counted burst sequencer.
// Define USR_LFSR_EN to turn MODE 111 into a tapped-feedback shift up.
module universal_shift_register #(
    parameter int N = 4,
    parameter int W = 1,
    parameter int CW = 4,
    parameter logic [N-1:0] TAPS = {N{1'b1}}
) (
    input  logic           CLK,
    input  logic           CLR,
    input  logic           EN,
    input  logic [2:0]     MODE,
    input  logic [W-1:0]   SIN_LO,
    input  logic [W-1:0]   SIN_HI,
    input  logic [N*W-1:0] D,
    input  logic           START,
    input  logic [CW-1:0]  CNT,
    output logic [N*W-1:0] Q,
    output logic [W-1:0]   SOUT_LO,
    output logic [W-1:0]   SOUT_HI,
    output logic           BUSY,
    output logic           DONE
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   rem, rem_n;
    logic [2:0]      lmode, lmode_n;
    logic            done_n;
    logic            do_step;
    logic [2:0]      op;
    logic [N*W-1:0]  q_n;
    logic            burst_ok;
    logic [W-1:0]    cur [N];
    logic [W-1:0]    nxt [N];
    logic [W-1:0]    fb;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= IDLE;
            rem   <= '0;
            lmode <= '0;
            DONE  <= 1'b0;
            Q     <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            lmode <= lmode_n;
            DONE  <= done_n;
            Q     <= q_n;
        end
    end

`ifdef USR_LFSR_EN
    assign burst_ok = (MODE inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b111});
`else
    assign burst_ok = (MODE inside {3'b001, 3'b010, 3'b011, 3'b100});
`endif

    always_comb begin
        state_n = state;
        rem_n   = rem;
        lmode_n = lmode;
        done_n  = 1'b0;
        do_step = 1'b0;
        op      = MODE;
        unique case (state)
            IDLE: begin
                if (START && burst_ok) begin
                    lmode_n = MODE;
                    rem_n   = CNT;
                    if (CNT != '0) state_n = RUN;
                    else           done_n  = 1'b1;
                end else begin
                    do_step = EN;
                end
            end
            RUN: begin
                op = lmode;
                if (EN) begin
                    do_step = 1'b1;
                    rem_n   = rem - 1'b1;
                    if (rem == CW'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath works on unpacked stages; stage 0 is the low word of Q.
    always_comb begin
        for (int i = 0; i < N; i++) cur[i] = Q[i*W +: W];
        fb = '0;
`ifdef USR_LFSR_EN
        for (int i = 0; i < N; i++)
            if (TAPS[i]) fb = fb ^ cur[i];
`endif
        nxt = cur;
        if (do_step) begin
            unique case (op)
                3'b001: begin
                    nxt[0] = SIN_LO;
                    for (int i = 1; i < N; i++) nxt[i] = cur[i-1];
                end
                3'b010: begin
                    nxt[N-1] = SIN_HI;
                    for (int i = 0; i < N-1; i++) nxt[i] = cur[i+1];
                end
                3'b011: begin
                    nxt[0] = cur[N-1];
                    for (int i = 1; i < N; i++) nxt[i] = cur[i-1];
                end
                3'b100: begin
                    nxt[N-1] = cur[0];
                    for (int i = 0; i < N-1; i++) nxt[i] = cur[i+1];
                end
                3'b101: begin
                    for (int i = 0; i < N; i++) nxt[i] = D[i*W +: W];
                end
                3'b110: begin
                    for (int i = 0; i < N; i++) nxt[i] = '0;
                end
`ifdef USR_LFSR_EN
                3'b111: begin
                    nxt[0] = fb;
                    for (int i = 1; i < N; i++) nxt[i] = cur[i-1];
                end
`endif
                default: ;
            endcase
        end
        for (int i = 0; i < N; i++) q_n[i*W +: W] = nxt[i];
    end

    assign BUSY    = (state == RUN);
    assign SOUT_LO = Q[W-1:0];
    assign SOUT_HI = Q[N*W-1 -: W];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register at N=4, W=4.
// Define USR_LFSR_EN to also exercise the feedback mode.
module tb_universal_shift_register;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        EN = 1'b0;
    logic [2:0]  MODE = 3'b000;
    logic [3:0]  SIN_LO = '0;
    logic [3:0]  SIN_HI = '0;
    logic [15:0] D = '0;
    logic        START = 1'b0;
    logic [3:0]  CNT = '0;
    logic [15:0] Q;
    logic [3:0]  SOUT_LO;
    logic [3:0]  SOUT_HI;
    logic        BUSY;
    logic        DONE;

    int vectors = 0;
    int errors = 0;

    universal_shift_register #(
        .N(4), .W(4), .CW(4), .TAPS(4'b1001)
    ) dut (
        .CLK(CLK), .CLR(CLR), .EN(EN), .MODE(MODE),
        .SIN_LO(SIN_LO), .SIN_HI(SIN_HI), .D(D),
        .START(START), .CNT(CNT), .Q(Q),
        .SOUT_LO(SOUT_LO), .SOUT_HI(SOUT_HI),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [15:0] v);
        START = 1'b0; MODE = 3'b101; D = v; EN = 1'b1;
        tick();
        EN = 1'b0; MODE = 3'b000;
    endtask

    task automatic test_reset();
        #3 CLR = 1'b0;
        #1;
        vectors++;
        if (Q !== 16'h0) begin
            errors++; $display("FAIL reset_q got %h want 0000", Q);
        end
        vectors++;
        if (SOUT_LO !== 4'h0 || SOUT_HI !== 4'h0) begin
            errors++;
            $display("FAIL reset_sout got %h/%h want 0/0", SOUT_LO, SOUT_HI);
        end
        vectors++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got %b%b want 00", BUSY, DONE);
        end
        tick(); tick();
        CLR = 1'b1;
        tick();
    endtask

    task automatic test_load_hold();
        load(16'h1234);
        vectors++;
        if (Q !== 16'h1234) begin
            errors++; $display("FAIL load got %h want 1234", Q);
        end
        EN = 1'b0; MODE = 3'b001; SIN_LO = 4'hA;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (Q !== 16'h1234) begin
                errors++; $display("FAIL hold%0d got %h want 1234", i, Q);
            end
        end
    endtask

    task automatic test_shift_up();
        MODE = 3'b001; SIN_LO = 4'hA; EN = 1'b1;
        #1;
        vectors++;
        if (SOUT_HI !== 4'h1) begin
            errors++; $display("FAIL sout_hi_pre got %h want 1", SOUT_HI);
        end
        tick();
        EN = 1'b0;
        vectors++;
        if (Q !== 16'h234A || SOUT_HI !== 4'h2 || SOUT_LO !== 4'hA) begin
            errors++;
            $display("FAIL shift_up got %h hi=%h lo=%h want 234a hi=2 lo=a",
                     Q, SOUT_HI, SOUT_LO);
        end
    endtask

    task automatic test_clear();
        MODE = 3'b110; EN = 1'b1;
        tick();
        EN = 1'b0;
        vectors++;
        if (Q !== 16'h0) begin
            errors++; $display("FAIL sync_clear got %h want 0000", Q);
        end
    endtask

    task automatic test_rotate_burst();
        int n;
        load(16'h1234);
        START = 1'b1; MODE = 3'b100; CNT = 4'd3; EN = 1'b1;
        tick();
        START = 1'b0; MODE = 3'b110;
        vectors++;
        if (Q !== 16'h1234 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL rot_accept got q=%h busy=%b want 1234/1", Q, BUSY);
        end
        n = 0;
        while (BUSY === 1'b1 && n < 20) begin
            tick(); n++;
        end
        vectors++;
        if (n != 3 || Q !== 16'h2341 || DONE !== 1'b1) begin
            errors++;
            $display("FAIL rot_burst got n=%0d q=%h done=%b want 3/2341/1",
                     n, Q, DONE);
        end
        EN = 1'b0; MODE = 3'b000;
        tick();
        vectors++;
        if (DONE !== 1'b0 || Q !== 16'h2341) begin
            errors++;
            $display("FAIL rot_done_pulse got done=%b q=%h want 0/2341", DONE, Q);
        end
    endtask

    task automatic test_paused_burst();
        int n;
        int dones;
        load(16'h1234);
        START = 1'b1; MODE = 3'b010; SIN_HI = 4'hF; CNT = 4'd2; EN = 1'b1;
        tick();
        START = 1'b0; MODE = 3'b000; EN = 1'b0;
        tick();
        vectors++;
        if (Q !== 16'h1234 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL pause got q=%h busy=%b want 1234/1", Q, BUSY);
        end
        EN = 1'b1;
        n = 1; dones = 0;
        while (BUSY === 1'b1 && n < 20) begin
            tick(); n++;
            if (DONE === 1'b1) dones++;
        end
        vectors++;
        if (n != 3 || Q !== 16'hFF12 || DONE !== 1'b1) begin
            errors++;
            $display("FAIL paused_burst got n=%0d q=%h done=%b want 3/ff12/1",
                     n, Q, DONE);
        end
        EN = 1'b0;
        tick();
        if (DONE === 1'b1) dones++;
        vectors++;
        if (dones != 1) begin
            errors++; $display("FAIL paused_dones got %0d want 1", dones);
        end
    endtask

    task automatic test_zero_count();
        START = 1'b1; MODE = 3'b001; CNT = 4'd0; EN = 1'b1;
        tick();
        START = 1'b0; EN = 1'b0;
        vectors++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || Q !== 16'hFF12) begin
            errors++;
            $display("FAIL zero_cnt got done=%b busy=%b q=%h want 1/0/ff12",
                     DONE, BUSY, Q);
        end
        tick();
        vectors++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL zero_cnt_after got done=%b busy=%b want 0/0", DONE, BUSY);
        end
    endtask

    task automatic test_back_to_back();
        START = 1'b1; MODE = 3'b011; CNT = 4'd1; EN = 1'b1;
        tick();
        tick();
        vectors++;
        if (Q !== 16'hF12F || DONE !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got q=%h done=%b busy=%b want f12f/1/0",
                     Q, DONE, BUSY);
        end
        tick();
        START = 1'b0;
        vectors++;
        if (Q !== 16'hF12F || DONE !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got q=%h done=%b busy=%b want f12f/0/1",
                     Q, DONE, BUSY);
        end
        tick();
        EN = 1'b0;
        vectors++;
        if (Q !== 16'h12FF || DONE !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got q=%h done=%b busy=%b want 12ff/1/0",
                     Q, DONE, BUSY);
        end
        tick();
    endtask

    task automatic test_invalid_start();
        START = 1'b1; MODE = 3'b101; D = 16'hABCD; CNT = 4'd3; EN = 1'b1;
        tick();
        vectors++;
        if (Q !== 16'hABCD || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL start_load got q=%h busy=%b done=%b want abcd/0/0",
                     Q, BUSY, DONE);
        end
        START = 1'b0; EN = 1'b0;
    endtask

    task automatic test_mode7();
`ifdef USR_LFSR_EN
        load(16'h1234);
        MODE = 3'b111; EN = 1'b1;
        tick();
        EN = 1'b0;
        vectors++;
        if (Q !== 16'h2345) begin
            errors++; $display("FAIL lfsr_step got %h want 2345", Q);
        end
`else
        load(16'h1234);
        START = 1'b1; MODE = 3'b111; CNT = 4'd2; EN = 1'b1;
        tick();
        START = 1'b0; EN = 1'b0;
        vectors++;
        if (Q !== 16'h1234 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL mode7_hold got q=%h busy=%b done=%b want 1234/0/0",
                     Q, BUSY, DONE);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int dones;
        load(16'h1234);
        START = 1'b1; MODE = 3'b100; CNT = 4'd5; EN = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick();
        vectors++;
        if (Q !== 16'h3412 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL mid_steps got q=%h busy=%b want 3412/1", Q, BUSY);
        end
        #2 CLR = 1'b0;
        #1;
        vectors++;
        if (Q !== 16'h0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL async_clr got q=%h busy=%b done=%b want 0000/0/0",
                     Q, BUSY, DONE);
        end
        tick();
        CLR = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (DONE === 1'b1 || BUSY === 1'b1) dones++;
        end
        EN = 1'b0;
        vectors++;
        if (dones != 0 || Q !== 16'h0) begin
            errors++;
            $display("FAIL post_clr got flags=%0d q=%h want 0/0000", dones, Q);
        end
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_shift_up();
        test_clear();
        test_rotate_burst();
        test_paused_burst();
        test_zero_count();
        test_back_to_back();
        test_invalid_start();
        test_mode7();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
